// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display path: MAX7219 segment bit order,
// glyph constants, the Code-B and hexadecimal font tables, and the font lookup.
package seg7_pkg;

  // Segment bit positions inside a 7-bit glyph {A,B,C,D,E,F,G}.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam int SEG_W   = 7;
  localparam int CODE_W  = 4;
  localparam int N_CODES = 16;

  typedef logic [SEG_W-1:0]  glyph_t;
  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic {
    FONT_CODE_B = 1'b0,
    FONT_HEX    = 1'b1
  } font_sel_e;

  // Non-numeric glyphs used by the Code-B font.
  localparam glyph_t GLYPH_BLANK = 7'h00;
  localparam glyph_t GLYPH_DASH  = 7'b1 << SEG_G;
  localparam glyph_t GLYPH_E     = (7'b1 << SEG_A) | (7'b1 << SEG_D) | (7'b1 << SEG_E)
                                 | (7'b1 << SEG_F) | (7'b1 << SEG_G);
  localparam glyph_t GLYPH_H     = (7'b1 << SEG_B) | (7'b1 << SEG_C) | (7'b1 << SEG_E)
                                 | (7'b1 << SEG_F) | (7'b1 << SEG_G);
  localparam glyph_t GLYPH_L     = (7'b1 << SEG_D) | (7'b1 << SEG_E) | (7'b1 << SEG_F);
  localparam glyph_t GLYPH_P     = (7'b1 << SEG_A) | (7'b1 << SEG_B) | (7'b1 << SEG_E)
                                 | (7'b1 << SEG_F) | (7'b1 << SEG_G);

  localparam glyph_t CODEB_FONT [N_CODES] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, GLYPH_DASH, GLYPH_E, GLYPH_H, GLYPH_L, GLYPH_P, GLYPH_BLANK
  };

  // Digits 0-9 are shared with Code-B; A..F are the usual mixed-case hex letters.
  localparam glyph_t HEX_FONT_TBL [N_CODES] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Explicit case over all known codes so an unknown code falls to the dark glyph.
  function automatic glyph_t seg7_decode(input code_t code, input font_sel_e font);
    glyph_t g;
    g = GLYPH_BLANK;
    case (code)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: begin
        if (font == FONT_HEX) g = HEX_FONT_TBL[code];
        else                  g = CODEB_FONT[code];
      end
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One registered digit decoder: 4-bit code in, 7 segment drives out one clock later.
// There is no handshake; a new code may be presented every cycle.
module bcd_to_7seg
  import seg7_pkg::*;
#(
  parameter int unsigned HEX_FONT = 0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_bcd,
  output logic [6:0] o_led
);

  localparam font_sel_e FONT = (HEX_FONT != 0) ? FONT_HEX : FONT_CODE_B;

  glyph_t led_d;
  glyph_t led_q;

  always_comb begin
    led_d = seg7_decode(i_bcd, FONT);
  end

  // Reset takes priority over a code arriving on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) led_q <= GLYPH_BLANK;
    else         led_q <= led_d;
  end

  assign o_led = led_q;

endmodule

// File: tb/tb_bcd_to_7seg.sv
// Bench for bcd_to_7seg: both fonts side by side, checked against a segment-letter model.
module tb_bcd_to_7seg;

  logic       clk;
  logic       reset;
  logic [3:0] bcd;
  logic [6:0] led_cb;
  logic [6:0] led_hx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] exp_cb_q[$];
  logic [6:0] exp_hx_q[$];

  // Glyphs described by the letters of their lit segments.
  string codeb_segs [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "g", "adefg", "bcefg", "def", "abefg", ""
  };
  string hex_segs [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"
  };

  bcd_to_7seg #(.HEX_FONT(0)) dut_cb (
    .i_clk(clk), .i_reset(reset), .i_bcd(bcd), .o_led(led_cb)
  );

  bcd_to_7seg #(.HEX_FONT(1)) dut_hx (
    .i_clk(clk), .i_reset(reset), .i_bcd(bcd), .o_led(led_hx)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_from_str(input string s);
    logic [6:0] g;
    int idx;
    g = 7'h00;
    for (int i = 0; i < s.len(); i++) begin
      idx = int'(s[i]) - 97;
      g[6 - idx] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [6:0] model(input logic rst, input logic [3:0] code, input bit hex);
    if (rst) return 7'h00;
    return hex ? seg_from_str(hex_segs[code]) : seg_from_str(codeb_segs[code]);
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Driver: present inputs, advance one edge, then score both instances.
  task automatic apply(input logic rst, input logic [3:0] code, input string tag);
    reset = rst;
    bcd   = code;
    exp_cb_q.push_back(model(rst, code, 1'b0));
    exp_hx_q.push_back(model(rst, code, 1'b1));
    @(posedge clk);
    #1;
    check({tag, "_cb"}, led_cb, exp_cb_q.pop_front());
    check({tag, "_hx"}, led_hx, exp_hx_q.pop_front());
  endtask

  initial begin
    reset = 1'b1;
    bcd   = 4'h8;

    // Reset held with 8 waiting, then release.
    apply(1'b1, 4'h8, "rst_hold0");
    apply(1'b1, 4'h8, "rst_hold1");
    apply(1'b0, 4'h8, "rst_release");
    check("release_8_const", led_cb, 7'h7F);

    // Full sweep of both fonts.
    for (int c = 0; c < 16; c++) begin
      apply(1'b0, 4'(c), $sformatf("sweep_%0h", c));
    end

    // Spot values from the glyph tables.
    apply(1'b0, 4'h3, "spot3");  check("cb_3", led_cb, 7'h79);
    apply(1'b0, 4'hA, "spotA");  check("cb_A", led_cb, 7'h01); check("hx_A", led_hx, 7'h77);
    apply(1'b0, 4'hC, "spotC");  check("cb_C", led_cb, 7'h37);
    apply(1'b0, 4'hB, "spotB");  check("hx_b", led_hx, 7'h1F);
    apply(1'b0, 4'hD, "spotD");  check("hx_d", led_hx, 7'h3D);
    apply(1'b0, 4'hF, "spotF");  check("cb_F", led_cb, 7'h00); check("hx_F", led_hx, 7'h47);

    // Reset on the same edge the code changes 0 -> 1.
    apply(1'b0, 4'h0, "pre_rst0");
    apply(1'b1, 4'h1, "rst_same_edge");
    check("rst_same_edge_const", led_cb, 7'h00);
    apply(1'b0, 4'h1, "post_rst1");
    check("post_rst1_const", led_cb, 7'h30);

    // Back-to-back codes: each appears exactly once, one edge later.
    apply(1'b0, 4'h5, "seq5"); check("seq5_const", led_cb, 7'h5B);
    apply(1'b0, 4'h2, "seq2"); check("seq2_const", led_cb, 7'h6D);
    apply(1'b0, 4'h9, "seq9"); check("seq9_const", led_cb, 7'h7B);
    apply(1'b0, 4'h0, "seq0"); check("seq0_const", led_cb, 7'h7E);

    // Random codes with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
